hazard_forward_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 35 +++
 rtl/hazard_shadow_stage.sv | 28 ++
 rtl/hazard_forward_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding controller: the shadow
// pipeline entry layout, forwarding select encodings and the nearest-match search.
package hazard_pkg;

    localparam int HZ_AW          = 5;
    localparam int HZ_NUM_SRC     = 2;
    localparam int HZ_MAX_STAGES  = 16;

    localparam int SEL_RF  = 0;
    localparam int SEL_MEM = 1;
    localparam int SEL_WB  = 2;

    typedef struct packed {
        logic                                  valid;
        logic [HZ_AW-1:0]                      dst;
        logic                                  rw;
        logic                                  load;
        logic                                  store;
        logic [HZ_NUM_SRC-1:0][HZ_AW-1:0]      src;
        logic [HZ_NUM_SRC-1:0]                 used;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // A live entry that writes a non-zero register equal to regNum.
    function automatic logic isWriterOf(entry_t e, logic [HZ_AW-1:0] regNum);
        return e.valid && e.rw && (e.dst != '0) && (e.dst == regNum);
    endfunction

    // Keeps only the lowest set bit, i.e. the youngest stage that matched.
    function automatic logic [HZ_MAX_STAGES-1:0] youngestHit(logic [HZ_MAX_STAGES-1:0] hits);
        return hits & (~hits + 1'b1);
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One register of the shadow instruction pipeline; kill clears the entry even
// while the pipeline is frozen.
module hazard_shadow_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         kill,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] entryReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entryReg <= '0;
        end else if (kill) begin
            entryReg <= '0;
        end else if (!hold) begin
            entryReg <= d;
        end
    end

    assign q = entryReg;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller tracking in-flight instructions in a shadow
// pipeline. Define HAZARD_PERF_EN to add the stall_count performance counter.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [NUM_SRC*AW-1:0]      id_src_addr,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [AW-1:0]              id_dst_addr,
    input  logic                       id_reg_write,
    input  logic                       id_mem_to_reg,
    input  logic                       id_mem_write,
    input  logic                       pipe_hold,
    input  logic                       flush,
    output logic                       stall_id,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       fwd_store,
    output logic                       ex_valid
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]                stall_count
`endif
);

    generate
        if (AW != HZ_AW || NUM_SRC != HZ_NUM_SRC) begin : gBadEntryShape
            $error("hazard_forward_ctrl: AW/NUM_SRC must match the hazard_pkg entry layout");
        end
        if (FWD_STAGES < LOAD_LAT + 1 || FWD_STAGES + 1 > HZ_MAX_STAGES) begin : gBadDepth
            $error("hazard_forward_ctrl: FWD_STAGES out of range for LOAD_LAT");
        end
    endgenerate

    entry_t stageQ [FWD_STAGES+1];
    entry_t idEntry;
    entry_t exNext;
    logic   stallLoad;

    always_comb begin
        idEntry       = '0;
        idEntry.valid = id_valid;
        idEntry.dst   = id_dst_addr;
        idEntry.rw    = id_reg_write;
        idEntry.load  = id_mem_to_reg;
        idEntry.store = id_mem_write;
        idEntry.src   = id_src_addr;
        idEntry.used  = id_src_used;
    end

    assign stall_id = pipe_hold || stallLoad;
    assign exNext   = (id_valid && !stall_id && !flush) ? idEntry : '0;

    // Stage 0 is EX; stage k is k steps older (1=MEM, 2=WB, ...).
    genvar gi;
    generate
        for (gi = 0; gi <= FWD_STAGES; gi++) begin : gStage
            logic [ENTRY_W-1:0] dBits;
            logic [ENTRY_W-1:0] qBits;
            if (gi == 0) begin : gEx
                assign dBits = exNext;
            end else begin : gOlder
                assign dBits = stageQ[gi-1];
            end
            hazard_shadow_stage #(
                .W(ENTRY_W)
            ) uStage (
                .clk  (clk),
                .rst  (rst),
                .hold (pipe_hold),
                .kill ((gi == 0) ? flush : 1'b0),
                .d    (dBits),
                .q    (qBits)
            );
            assign stageQ[gi] = qBits;
        end
    endgenerate

    assign ex_valid = stageQ[0].valid;

    // Load-use: the youngest writer of an ID source is a load whose data is not
    // yet forwardable. A store's data operand right behind a load is instead
    // patched in MEM through fwd_store.
    logic [HZ_MAX_STAGES-1:0] idHits;
    logic [HZ_MAX_STAGES-1:0] idNearest;
    logic [HZ_MAX_STAGES-1:0] earlyLoad;

    always_comb begin
        earlyLoad = '0;
        idHits    = '0;
        idNearest = '0;
        stallLoad = 1'b0;
        for (int s = 0; s < LOAD_LAT; s++) begin
            earlyLoad[s] = stageQ[s].valid && stageQ[s].load;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            idHits = '0;
            for (int s = 0; s < FWD_STAGES; s++) begin
                idHits[s] = isWriterOf(stageQ[s], idEntry.src[i]);
            end
            idNearest = youngestHit(idHits);
            if (id_src_used[i] && |(idNearest & earlyLoad)) begin
                if (!(LOAD_LAT == 1 && id_mem_write && i == 1)) begin
                    stallLoad = 1'b1;
                end
            end
        end
    end

    logic [HZ_MAX_STAGES-1:0] exHits;
    logic [HZ_MAX_STAGES-1:0] exNearest;
    logic [SEL_W-1:0]         selIdx;

    always_comb begin
        fwd_sel   = '0;
        exHits    = '0;
        exNearest = '0;
        selIdx    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            exHits = '0;
            for (int k = 1; k <= FWD_STAGES; k++) begin
                exHits[k] = isWriterOf(stageQ[k], stageQ[0].src[i])
                            && !(stageQ[k].load && k < 1 + LOAD_LAT);
            end
            exNearest = youngestHit(exHits);
            selIdx    = SEL_W'(SEL_RF);
            for (int k = 1; k <= FWD_STAGES; k++) begin
                if (exNearest[k]) begin
                    selIdx = SEL_W'(k);
                end
            end
            if (stageQ[0].used[i]) begin
                fwd_sel[i*SEL_W +: SEL_W] = selIdx;
            end
        end
    end

    generate
        if (FWD_STAGES >= SEL_WB) begin : gStoreFwd
            assign fwd_store = stageQ[SEL_MEM].valid && stageQ[SEL_MEM].store
                               && stageQ[SEL_MEM].used[1]
                               && isWriterOf(stageQ[SEL_WB], stageQ[SEL_MEM].src[1])
                               && stageQ[SEL_WB].load;
        end else begin : gNoStoreFwd
            assign fwd_store = 1'b0;
        end
    endgenerate

`ifdef HAZARD_PERF_EN
    logic [15:0] stallCountReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCountReg <= '0;
        end else if (stall_id && !pipe_hold && stallCountReg != 16'hFFFF) begin
            stallCountReg <= stallCountReg + 16'd1;
        end
    end

    assign stall_count = stallCountReg;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
`timescale 1ns/1ps
module tb_hazard_forward_ctrl;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int FS = 2;
    localparam int LL = 1;
    localparam int SW = $clog2(FS + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [NS*AW-1:0]  id_src_addr;
    logic [NS-1:0]     id_src_used;
    logic [AW-1:0]     id_dst_addr;
    logic              id_reg_write;
    logic              id_mem_to_reg;
    logic              id_mem_write;
    logic              pipe_hold;
    logic              flush;
    logic              stall_id;
    logic [NS*SW-1:0]  fwd_sel;
    logic              fwd_store;
    logic              ex_valid;
`ifdef HAZARD_PERF_EN
    logic [15:0]       stall_count;
`endif

    always #5 clk = ~clk;

    hazard_forward_ctrl #(
        .AW(AW), .NUM_SRC(NS), .FWD_STAGES(FS), .LOAD_LAT(LL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_src_addr   (id_src_addr),
        .id_src_used   (id_src_used),
        .id_dst_addr   (id_dst_addr),
        .id_reg_write  (id_reg_write),
        .id_mem_to_reg (id_mem_to_reg),
        .id_mem_write  (id_mem_write),
        .pipe_hold     (pipe_hold),
        .flush         (flush),
        .stall_id      (stall_id),
        .fwd_sel       (fwd_sel),
        .fwd_store     (fwd_store),
        .ex_valid      (ex_valid)
`ifdef HAZARD_PERF_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       rw;
        logic       load;
        logic       store;
        logic [4:0] src1;
        logic [4:0] src0;
        logic [1:0] used;
    } inst_t;

    typedef struct {
        int          step;
        logic        stall;
        logic [SW-1:0] sel0;
        logic [SW-1:0] sel1;
        logic        store;
        logic        exv;
        logic [15:0] cnt;
    } exp_t;

    exp_t  expQ[$];
    inst_t pipe [0:FS];
    inst_t curId;
    bit    curHold, curFlush, curRst, curStall;
    int    modelCnt;
    int    stepNo;
    int    nChecks;
    int    nPass;

    function automatic bit writes(inst_t p, logic [4:0] r);
        return p.valid && p.rw && p.dst != 0 && p.dst == r;
    endfunction

    function automatic logic [4:0] srcOf(inst_t p, int i);
        return (i == 1) ? p.src1 : p.src0;
    endfunction

    function automatic bit modelStall(inst_t id, bit hold);
        bit st;
        st = hold;
        for (int i = 0; i < 2; i++) begin
            if (id.used[i]) begin
                for (int s = 0; s < FS; s++) begin
                    if (writes(pipe[s], srcOf(id, i))) begin
                        if (pipe[s].load && s < LL && !(LL == 1 && id.store && i == 1 && s == 0))
                            st = 1;
                        break;
                    end
                end
            end
        end
        return st;
    endfunction

    function automatic int modelSel(int i);
        if (!pipe[0].used[i]) return 0;
        for (int k = 1; k <= FS; k++) begin
            if (writes(pipe[k], srcOf(pipe[0], i)) && !(pipe[k].load && k < 1 + LL))
                return k;
        end
        return 0;
    endfunction

    function automatic bit modelStore();
        return pipe[1].valid && pipe[1].store && pipe[1].used[1]
               && writes(pipe[2], pipe[1].src1) && pipe[2].load;
    endfunction

    function automatic inst_t mkAlu(int d, int a, int b);
        inst_t x = '0;
        x.valid = 1; x.rw = 1; x.dst = 5'(d); x.src0 = 5'(a); x.src1 = 5'(b); x.used = 2'b11;
        return x;
    endfunction

    function automatic inst_t mkLw(int d, int base);
        inst_t x = '0;
        x.valid = 1; x.rw = 1; x.load = 1; x.dst = 5'(d); x.src0 = 5'(base); x.used = 2'b01;
        return x;
    endfunction

    function automatic inst_t mkSw(int base, int data);
        inst_t x = '0;
        x.valid = 1; x.store = 1; x.src0 = 5'(base); x.src1 = 5'(data); x.used = 2'b11;
        return x;
    endfunction

    function automatic inst_t mkBr(int a, int b);
        inst_t x = '0;
        x.valid = 1; x.src0 = 5'(a); x.src1 = 5'(b); x.used = 2'b11;
        return x;
    endfunction

    task automatic step(inst_t inst, bit hold, bit fl, bit rs);
        exp_t e;
        @(posedge clk);
        if (!curRst) begin
            if (!curHold) begin
                if (curStall && modelCnt < 16'hFFFF) modelCnt++;
                for (int k = FS; k > 0; k--) pipe[k] = pipe[k-1];
                pipe[0] = (curId.valid && !curStall && !curFlush) ? curId : '0;
            end else if (curFlush) begin
                pipe[0] = '0;
            end
        end
        #1;
        if (!curStall || curFlush || curRst || rs) curId = inst;
        curHold = hold; curFlush = fl; curRst = rs;
        if (rs) begin
            for (int k = 0; k <= FS; k++) pipe[k] = '0;
            modelCnt = 0;
        end
        rst           = curRst;
        pipe_hold     = curHold;
        flush         = curFlush;
        id_valid      = curId.valid;
        id_src_addr   = {curId.src1, curId.src0};
        id_src_used   = curId.used;
        id_dst_addr   = curId.dst;
        id_reg_write  = curId.rw;
        id_mem_to_reg = curId.load;
        id_mem_write  = curId.store;
        curStall = modelStall(curId, curHold);
        e.step  = stepNo;
        e.stall = curStall;
        e.sel0  = SW'(modelSel(0));
        e.sel1  = SW'(modelSel(1));
        e.store = modelStore();
        e.exv   = pipe[0].valid;
        e.cnt   = 16'(modelCnt);
        expQ.push_back(e);
        stepNo++;
    endtask

    initial begin : monitor
        exp_t e;
        bit ok;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e  = expQ.pop_front();
                ok = 1;
                nChecks++;
                if (stall_id === e.stall) nPass++;
                else begin
                    ok = 0;
                    $display("FAIL step %0d stall_id: got %0h, expected %0h", e.step, stall_id, e.stall);
                end
                nChecks++;
                if (fwd_sel[SW-1:0] === e.sel0) nPass++;
                else begin
                    ok = 0;
                    $display("FAIL step %0d fwd_sel0: got %0h, expected %0h", e.step, fwd_sel[SW-1:0], e.sel0);
                end
                nChecks++;
                if (fwd_sel[2*SW-1:SW] === e.sel1) nPass++;
                else begin
                    ok = 0;
                    $display("FAIL step %0d fwd_sel1: got %0h, expected %0h", e.step, fwd_sel[2*SW-1:SW], e.sel1);
                end
                nChecks++;
                if (fwd_store === e.store) nPass++;
                else begin
                    ok = 0;
                    $display("FAIL step %0d fwd_store: got %0h, expected %0h", e.step, fwd_store, e.store);
                end
                nChecks++;
                if (ex_valid === e.exv) nPass++;
                else begin
                    ok = 0;
                    $display("FAIL step %0d ex_valid: got %0h, expected %0h", e.step, ex_valid, e.exv);
                end
`ifdef HAZARD_PERF_EN
                nChecks++;
                if (stall_count === e.cnt) nPass++;
                else begin
                    ok = 0;
                    $display("FAIL step %0d stall_count: got %0h, expected %0h", e.step, stall_count, e.cnt);
                end
`endif
                $display("step %0d: stall=%0b sel=%0d/%0d store=%0b ex_valid=%0b %s",
                         e.step, stall_id, fwd_sel[SW-1:0], fwd_sel[2*SW-1:SW],
                         fwd_store, ex_valid, ok ? "ok" : "bad");
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        inst_t nop;
        nop = '0;
        nChecks = 0; nPass = 0; stepNo = 0; modelCnt = 0;
        for (int k = 0; k <= FS; k++) pipe[k] = '0;
        curId = '0; curHold = 0; curFlush = 0; curRst = 1; curStall = 0;
        rst = 1; pipe_hold = 0; flush = 0; id_valid = 0; id_src_addr = '0;
        id_src_used = '0; id_dst_addr = '0; id_reg_write = 0; id_mem_to_reg = 0; id_mem_write = 0;

        step(nop, 0, 0, 1);
        step(mkAlu(3, 1, 2), 0, 0, 1);
        step(mkAlu(3, 1, 2), 0, 0, 0);
        step(mkAlu(4, 3, 2), 0, 0, 0);
        step(mkAlu(6, 3, 0), 0, 0, 0);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 0);
        step(mkLw(5, 1), 0, 0, 0);
        step(mkAlu(7, 5, 1), 0, 0, 0);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 0);
        step(mkLw(5, 1), 0, 0, 0);
        step(mkSw(1, 5), 0, 0, 0);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 0);
        step(mkAlu(0, 1, 2), 0, 0, 0);
        step(mkAlu(8, 0, 0), 0, 0, 0);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 0);
        step(mkAlu(9, 1, 2), 0, 0, 0);
        step(mkAlu(9, 2, 3), 0, 0, 0);
        step(mkAlu(10, 9, 9), 0, 0, 0);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 0);
        step(mkLw(11, 1), 0, 0, 0);
        step(mkAlu(12, 11, 2), 1, 0, 0);
        step(nop, 1, 0, 0);
        step(nop, 1, 1, 0);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 0);
        step(mkAlu(12, 1, 2), 0, 0, 0);
        step(mkLw(13, 12), 0, 0, 0);
        step(mkAlu(14, 13, 12), 0, 0, 1);
        step(nop, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            inst_t x;
            int kind, d, a, b;
            x    = '0;
            kind = $urandom_range(0, 3);
            d    = $urandom_range(0, 7);
            a    = $urandom_range(0, 7);
            b    = $urandom_range(0, 7);
            if ($urandom_range(0, 9) != 0) begin
                case (kind)
                    0: x = mkAlu(d, a, b);
                    1: x = mkLw(d, a);
                    2: x = mkSw(a, b);
                    default: x = mkBr(a, b);
                endcase
            end
            step(x, $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 99) == 0);
        end
        step(nop, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
